// File: rtl/vespa_bus_pkg.sv
// Shared definitions for the VeSPA peripheral register bus.
package vespa_bus_pkg;

  localparam int BUS_W        = 32;
  localparam int RESP_LAT_MAX = 7;
  localparam int LAT_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_master_port.sv
// Initiator port of the VeSPA register bus: one transaction in flight,
// fixed-latency response capture and a saturating error counter.
module bus_master_port
  import vespa_bus_pkg::*;
#(
  parameter int RESP_LAT  = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_ReqValid,
  output logic                 o_ReqReady,
  input  logic                 i_ReqWrite,
  input  logic [BUS_W-1:0]     i_ReqAddr,
  input  logic [BUS_W-1:0]     i_ReqWData,
  output logic                 o_RspValid,
  input  logic                 i_RspReady,
  output logic [BUS_W-1:0]     o_RspRData,
  output logic                 o_RspErr,
  output logic                 o_WEnable,
  output logic [BUS_W-1:0]     o_WAddr,
  output logic [BUS_W-1:0]     o_WData,
  output logic                 o_REnable,
  output logic [BUS_W-1:0]     o_RAddr,
  input  logic [BUS_W-1:0]     i_RData,
  input  logic                 i_Err,
  output logic                 o_Busy,
  output logic [ERR_CNT_W-1:0] o_ErrCount
);

  // Out-of-range latencies are clamped so the counter can never wrap.
  localparam int LAT_LOAD = (RESP_LAT < 1) ? 1 :
    ((RESP_LAT > RESP_LAT_MAX) ? RESP_LAT_MAX : RESP_LAT);

  bus_state_e state_q, state_d;

  logic                 write_q;
  logic [LAT_W-1:0]     lat_q;
  logic [BUS_W-1:0]     waddr_q;
  logic [BUS_W-1:0]     wdata_q;
  logic [BUS_W-1:0]     raddr_q;
  logic [BUS_W-1:0]     rdata_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic accept;
  logic capture;

  assign accept  = (state_q == IDLE) && i_ReqValid;
  assign capture = (state_q == WAIT) && (lat_q == LAT_W'(1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    o_ReqReady = 1'b0;
    o_RspValid = 1'b0;
    o_WEnable  = 1'b0;
    o_REnable  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ReqReady = 1'b1;
        if (i_ReqValid) state_d = ISSUE;
      end
      ISSUE: begin
        o_WEnable = write_q;
        o_REnable = !write_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_W'(1)) state_d = RESP;
      end
      RESP: begin
        o_RspValid = 1'b1;
        if (i_RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus address/data only move on acceptance, so they hold between strobes.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else if (accept) begin
      write_q <= i_ReqWrite;
      if (i_ReqWrite) begin
        waddr_q <= i_ReqAddr;
        wdata_q <= i_ReqWData;
      end else begin
        raddr_q <= i_ReqAddr;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      lat_q <= '0;
    end else if (state_q == ISSUE) begin
      lat_q <= LAT_W'(LAT_LOAD);
    end else if (state_q == WAIT) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (capture) begin
      rdata_q <= write_q ? '0 : i_RData;
      err_q   <= i_Err;
      if (i_Err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign o_WAddr    = waddr_q;
  assign o_WData    = wdata_q;
  assign o_RAddr    = raddr_q;
  assign o_RspRData = rdata_q;
  assign o_RspErr   = err_q;
  assign o_ErrCount = err_cnt_q;
  assign o_Busy     = (state_q != IDLE);

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
Initiator end of the VeSPA peripheral register bus, the side that drives the enable/address/data bus that slave IPs (GPIO etc.) decode.
Accepts single register read/write requests from a requester (CPU load/store unit or DMA) over a valid/ready handshake.
Issues each request as a one-cycle bus strobe, samples the slave's registered response after a fixed latency, and returns read data plus error status over a second valid/ready handshake.
One outstanding transaction at a time; keeps a saturating bus-error counter.

Parameters:
RESP_LAT, 1, cycles from bus strobe cycle to the cycle in which slave o_RData/o_Err are valid (legal range 1..7)
ERR_CNT_W, 16, width of saturating error counter

Ports:
i_Clk  in  1  clock, all logic on rising edge
i_Rst_n  in  1  synchronous, active-low reset
i_ReqValid  in  1  request valid
o_ReqReady  out  1  block can accept a request
i_ReqWrite  in  1  1 = write, 0 = read
i_ReqAddr  in  32  register address
i_ReqWData  in  32  write data
o_RspValid  out  1  response valid
i_RspReady  in  1  requester accepts response
o_RspRData  out  32  read data (0 for writes)
o_RspErr  out  1  slave reported error
o_WEnable  out  1  bus write strobe
o_WAddr  out  32  bus write address
o_WData  out  32  bus write data
o_REnable  out  1  bus read strobe
o_RAddr  out  32  bus read address
i_RData  in  32  slave read data
i_Err  in  1  slave error flag
o_Busy  out  1  transaction in flight (state != IDLE)
o_ErrCount  out  ERR_CNT_W  saturating count of errored transactions

Behaviour:
- Reset (i_Rst_n=0 at an edge): state IDLE; every output 0 except o_ReqReady=1; latched request cleared; o_ErrCount=0. Applies mid-transaction: pending strobe/response discarded, no o_RspValid produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: o_ReqReady=1. i_ReqValid&o_ReqReady at edge A latches write/addr/wdata, goes to ISSUE.
- ISSUE (cycle A+1): exactly one of o_WEnable/o_REnable =1 for this single cycle. Address is driven on the matching o_WAddr/o_RAddr, data on o_WData. Latency counter loaded with RESP_LAT; go to WAIT.
- Address/data outputs hold their values after ISSUE until the next ISSUE. Enables are 0 in all other states. Both enables are never high together.
- WAIT: counter decrements each cycle. In the cycle where counter==1, i_RData and i_Err are captured into o_RspRData/o_RspErr (RData forced 0 for writes); go to RESP.
- RESP: o_RspValid=1, data/err stable. On i_RspReady go to IDLE, o_RspValid=0 next cycle. The response is held indefinitely under backpressure.
- Timing: accept at edge A, o_RspValid first high in cycle A+2+RESP_LAT (A+3 for RESP_LAT=1). Back-to-back throughput: one transaction per RESP_LAT+3 cycles.
- o_ReqReady=0 in ISSUE/WAIT/RESP; requests presented then are not accepted and have no effect.
- o_ErrCount increments by 1 on each capture with i_Err=1. It saturates at all-ones and never wraps.
- i_Err/i_RData outside the capture cycle are ignored; the slave's sticky error from a previous access has no effect.

Decomposition:
- Shared package vespa_bus_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), bus address/data width constant 32, RESP_LAT max 7.
- No sub-module; the FSM, latency counter and saturating counter live in one module.

Test Plan:
- Write 0x0000000F to addr 0, RESP_LAT=1, RspReady=1 -> o_WEnable high exactly cycle A+1 with WAddr=0, WData=0xF, REnable=0. o_RspValid at A+3 with RspErr=0, RspRData=0.
- Read addr 2, slave model returns 0x00000005 one cycle after strobe -> o_REnable single cycle with RAddr=2; o_RspRData=0x00000005, RspErr=0.
- Write addr 3, slave asserts i_Err=1 -> o_RspErr=1, o_ErrCount=1. Then read addr 0 with i_Err=0 -> RspErr=0, count stays 1.
- Hold i_RspReady=0 for 5 cycles during RESP while i_ReqValid=1 -> o_RspValid, RData, Err stable all 5 cycles; o_ReqReady=0; no second strobe until the response is accepted.
- Assert i_Rst_n=0 for one edge in WAIT -> next cycle state IDLE, ReqReady=1, RspValid=0, enables 0, ErrCount=0; stale slave response never surfaces.
- RESP_LAT=3 instance, slave model with 3-cycle delay returning 0xA5A5A5A5 -> o_RspValid first high at A+5 with 0xA5A5A5A5. Force 2^16+2 error transactions with ERR_CNT_W=16 -> o_ErrCount holds 0xFFFF.
